// File: rtl/stack_sequencer_pkg.sv
// Opcode set, state encoding and decode helpers shared by the stack sequencer files.
package stack_seq_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned ST_W  = 3;

  // Calculator core opcodes
  localparam logic [NIB_W-1:0] OP_PUSH = 4'h1;
  localparam logic [NIB_W-1:0] OP_POP  = 4'h2;
  localparam logic [NIB_W-1:0] OP_OUTL = 4'h3;
  localparam logic [NIB_W-1:0] OP_OUTH = 4'h4;
  localparam logic [NIB_W-1:0] OP_SWAP = 4'h5;
  localparam logic [NIB_W-1:0] OP_PUSF = 4'h6;
  localparam logic [NIB_W-1:0] OP_REPL = 4'h7;
  localparam logic [NIB_W-1:0] OP_BINA = 4'h8;
  localparam logic [NIB_W-1:0] OP_MULT = 4'h9;
  localparam logic [NIB_W-1:0] OP_IDIV = 4'hA;
  localparam logic [NIB_W-1:0] OP_CLFL = 4'hB;
  localparam logic [NIB_W-1:0] OP_HALT = 4'hF;

  // Sequencer states
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_CPU_RST = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT    = 3'd2;
  localparam logic [ST_W-1:0] ST_FETCH   = 3'd3;
  localparam logic [ST_W-1:0] ST_EXEC    = 3'd4;
  localparam logic [ST_W-1:0] ST_HALT    = 3'd5;

  // Number of exec cycles the core spends on an opcode (unknown opcodes take one)
  function automatic logic [1:0] exec_len(input logic [NIB_W-1:0] op);
    case (op)
      OP_BINA, OP_MULT, OP_IDIV: exec_len = 2'd2;
      OP_PUSH, OP_POP, OP_OUTL, OP_OUTH,
      OP_SWAP, OP_PUSF, OP_REPL, OP_CLFL: exec_len = 2'd1;
      default: exec_len = 2'd1;
    endcase
  endfunction

  // Opcodes whose operand is the following program word
  function automatic logic has_operand(input logic [NIB_W-1:0] op);
    has_operand = (op == OP_PUSH) || (op == OP_PUSF) ||
                  (op == OP_REPL) || (op == OP_BINA);
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Board-side control and core-side drive bundle of the stack sequencer.
interface stack_sequencer_if
  import stack_seq_pkg::*;
#(
  parameter int unsigned PC_W = 4
) ();

  logic             load_en;
  logic [NIB_W-1:0] load_nibble;
  logic             start;
  logic             step_mode;
  logic             step;
  logic [NIB_W-1:0] cpu_inbits;
  logic             cpu_rst;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             halted;

  // Board / controller side
  modport master (
    output load_en, load_nibble, start, step_mode, step,
    input  cpu_inbits, cpu_rst, pc, busy, halted
  );

  // Sequencer side
  modport slave (
    input  load_en, load_nibble, start, step_mode, step,
    output cpu_inbits, cpu_rst, pc, busy, halted
  );

endinterface

// File: rtl/stack_sequencer_prog_mem.sv
// Program store: one write port, two asynchronous read ports (pc and pc+1), no reset.
module seq_prog_mem
  import stack_seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PC_W       = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PC_W-1:0]  waddr_i,
  input  logic [NIB_W-1:0] wdata_i,
  input  logic [PC_W-1:0]  raddr0_i,
  input  logic [PC_W-1:0]  raddr1_i,
  output logic [NIB_W-1:0] rdata0_c_o,
  output logic [NIB_W-1:0] rdata1_c_o
);

  logic [NIB_W-1:0] mem [PROG_DEPTH];

  // Serial program load; contents survive rst_n
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata0_c_o = mem[raddr0_i];
  assign rdata1_c_o = mem[raddr1_i];

endmodule

// File: rtl/stack_sequencer.sv
// Stack calculator program sequencer: loads a nibble program, resets the core and
// streams opcode/operand nibbles to it. Define STACK_SEQ_LOOP_EN to restart at pc 0
// instead of halting at the end of the program.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PC_W       = 4
) (
  input logic              clk,
  input logic              rst_n,
  stack_sequencer_if.slave bus
);

  localparam int unsigned LEN_W = PC_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(PROG_DEPTH);
`ifdef STACK_SEQ_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  logic [ST_W-1:0]  state_q, state_d;
  logic [LEN_W-1:0] load_ptr_q, load_ptr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [NIB_W-1:0] op_q, op_d;
  logic             exec_cnt_q, exec_cnt_d;
  logic             rst_cnt_q, rst_cnt_d;
  logic [NIB_W-1:0] cpu_inbits_q, cpu_inbits_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;

  logic             mem_we_c;
  logic [PC_W-1:0]  rd_addr1_c;
  logic [NIB_W-1:0] rd0_c, rd1_c;
  logic [LEN_W-1:0] pc_adv_c;
  logic             prog_end_c;
  logic             operand_ok_c;
  logic             last_exec_c;

  assign pc_adv_c     = {1'b0, pc_q} + (has_operand(op_q) ? LEN_W'(2) : LEN_W'(1));
  assign prog_end_c   = (pc_adv_c >= load_ptr_q);
  assign operand_ok_c = (({1'b0, pc_q} + LEN_W'(1)) < load_ptr_q);
  assign last_exec_c  = (state_q == ST_EXEC) && !exec_cnt_q;
  assign rd_addr1_c   = pc_d + PC_W'(1);

  seq_prog_mem #(
    .PROG_DEPTH (PROG_DEPTH),
    .PC_W       (PC_W)
  ) u_mem (
    .clk        (clk),
    .we_i       (mem_we_c),
    .waddr_i    (load_ptr_q[PC_W-1:0]),
    .wdata_i    (bus.load_nibble),
    .raddr0_i   (pc_d),
    .raddr1_i   (rd_addr1_c),
    .rdata0_c_o (rd0_c),
    .rdata1_c_o (rd1_c)
  );

  // Next program counter; memory is read at the pc the next cycle will present
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      ST_IDLE, ST_CPU_RST: pc_d = '0;
      ST_HALT:  if (bus.start) pc_d = '0;
      ST_FETCH: if (LOOP_EN && op_q == OP_HALT) pc_d = '0;
      ST_EXEC:  if (last_exec_c) pc_d = (LOOP_EN && prog_end_c) ? '0 : pc_adv_c[PC_W-1:0];
      default: ;
    endcase
  end

  // Next state, load bookkeeping and next registered outputs
  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    op_d         = op_q;
    exec_cnt_d   = exec_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    mem_we_c     = 1'b0;
    cpu_inbits_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_en) begin
          if (load_ptr_q != DEPTH_L) begin
            mem_we_c   = 1'b1;
            load_ptr_d = load_ptr_q + LEN_W'(1);
          end
        end else if (bus.start && load_ptr_q != '0) begin
          state_d   = ST_CPU_RST;
          rst_cnt_d = 1'b1;
        end
      end
      ST_CPU_RST: begin
        if (rst_cnt_q) rst_cnt_d = 1'b0;
        else           state_d   = bus.step_mode ? ST_WAIT : ST_FETCH;
      end
      ST_WAIT: begin
        if (bus.step) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (op_q == OP_HALT) begin
          state_d = LOOP_EN ? (bus.step_mode ? ST_WAIT : ST_FETCH) : ST_HALT;
        end else begin
          exec_cnt_d = 1'(exec_len(op_q) - 2'd1);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_cnt_q)                   exec_cnt_d = 1'b0;
        else if (prog_end_c && !LOOP_EN)  state_d    = ST_HALT;
        else                              state_d    = bus.step_mode ? ST_WAIT : ST_FETCH;
      end
      ST_HALT: begin
        if (bus.load_en && bus.start) begin
          state_d    = ST_IDLE;
          load_ptr_d = '0;
        end else if (bus.start && !bus.load_en) begin
          state_d   = ST_CPU_RST;
          rst_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_rst_d = (state_d == ST_CPU_RST);
    busy_d    = (state_d == ST_CPU_RST) || (state_d == ST_FETCH) || (state_d == ST_EXEC);
    halted_d  = (state_d == ST_HALT);
    case (state_d)
      ST_FETCH: begin
        cpu_inbits_d = rd0_c;
        op_d         = rd0_c;
      end
      ST_EXEC: begin
        if (state_q == ST_FETCH)
          cpu_inbits_d = (has_operand(op_q) && operand_ok_c) ? rd1_c : '0;
        else
          cpu_inbits_d = cpu_inbits_q;
      end
      default: ;
    endcase
  end

  // State and output registers; core held in reset while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      load_ptr_q   <= '0;
      pc_q         <= '0;
      op_q         <= '0;
      exec_cnt_q   <= 1'b0;
      rst_cnt_q    <= 1'b0;
      cpu_inbits_q <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      pc_q         <= pc_d;
      op_q         <= op_d;
      exec_cnt_q   <= exec_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      cpu_inbits_q <= cpu_inbits_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.cpu_inbits = cpu_inbits_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.pc         = pc_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: load, free-run, step mode, reset abort, boundaries.
module tb_stack_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] e2_nib [13];
  logic [3:0] e2_pc  [13];

  stack_sequencer_if #(.PC_W(4)) bus ();

  stack_sequencer #(
    .PROG_DEPTH (16),
    .PC_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_nib(input logic [3:0] v);
    bus.load_en     = 1'b1;
    bus.load_nibble = v;
    tick();
    bus.load_en     = 1'b0;
  endtask

  task automatic start_prog();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_prog();
    bus.load_en = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
  endtask

  task automatic load_prog2();
    load_nib(4'h1); load_nib(4'h3); load_nib(4'h1); load_nib(4'h4);
    load_nib(4'h9); load_nib(4'h3); load_nib(4'hF);
  endtask

  // Starts program 2 and checks 13 cycles of nibble and pc stream
  task automatic run_prog2(input string tag);
    start_prog();
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      check($sformatf("%s nib%0d", tag, i), 32'(bus.cpu_inbits), 32'(e2_nib[i]));
      check($sformatf("%s pc%0d", tag, i), 32'(bus.pc), 32'(e2_pc[i]));
    end
    check({tag, " halted"}, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    logic [3:0] e1 [8];
    e1     = '{4'h0, 4'h0, 4'h1, 4'h5, 4'h3, 4'h0, 4'hF, 4'h0};
    e2_nib = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h1, 4'h4, 4'h9, 4'h0, 4'h0, 4'h3, 4'h0, 4'hF, 4'h0};
    e2_pc  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6};

    rst_n           = 1'b0;
    bus.load_en     = 1'b0;
    bus.load_nibble = 4'h0;
    bus.start       = 1'b0;
    bus.step_mode   = 1'b0;
    bus.step        = 1'b0;

    // Reset values
    tick(); tick();
    check("rst cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rst inbits", 32'(bus.cpu_inbits), 32'd0);
    check("rst pc", 32'(bus.pc), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst halted", 32'(bus.halted), 32'd0);
    check("rst load_ptr", 32'(dut.load_ptr_q), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst release cpu_rst", 32'(bus.cpu_rst), 32'd0);

    // PUSH 5, OUTL, HALT
    load_nib(4'h1); load_nib(4'h5); load_nib(4'h3); load_nib(4'hF);
    check("p1 load_ptr", 32'(dut.load_ptr_q), 32'd4);
    start_prog();
    check("p1 busy at cpu_rst", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check($sformatf("p1 nib%0d", i), 32'(bus.cpu_inbits), 32'(e1[i]));
      check($sformatf("p1 cpu_rst%0d", i), 32'(bus.cpu_rst), (i < 2) ? 32'd1 : 32'd0);
    end
    check("p1 halted", 32'(bus.halted), 32'd1);
    check("p1 busy halt", 32'(bus.busy), 32'd0);
    check("p1 pc halt", 32'(bus.pc), 32'd3);

    // load_en alone in HALT is not accepted
    load_nib(4'h7);
    check("halt load ignored", 32'(dut.load_ptr_q), 32'd4);
    check("halt load halted", 32'(bus.halted), 32'd1);

    // Clear, then PUSH 3, PUSH 4, MULT, OUTL, HALT
    clear_prog();
    check("clear halted", 32'(bus.halted), 32'd0);
    check("clear load_ptr", 32'(dut.load_ptr_q), 32'd0);
    load_prog2();
    run_prog2("p2");

    // Restart and abort with rst_n during MULT exec
    start_prog();
    for (int i = 0; i < 7; i++) tick();
    check("abort pc before", 32'(bus.pc), 32'd4);
    check("abort busy before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("abort inbits", 32'(bus.cpu_inbits), 32'd0);
    check("abort pc", 32'(bus.pc), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort mem4", 32'(dut.u_mem.mem[4]), 32'h9);
    check("abort mem6", 32'(dut.u_mem.mem[6]), 32'hF);
    check("abort load_ptr", 32'(dut.load_ptr_q), 32'd0);
    start_prog();
    check("empty start busy", 32'(bus.busy), 32'd0);
    check("empty start cpu_rst", 32'(bus.cpu_rst), 32'd0);
    load_prog2();
    run_prog2("p2 rerun");

    // BINA with operand as last word
    clear_prog();
    load_nib(4'h8); load_nib(4'h0);
    start_prog();
    tick(); tick();
    check("bina fetch", 32'(bus.cpu_inbits), 32'h8);
    tick();
    check("bina exec0", 32'(bus.cpu_inbits), 32'h0);
    check("bina exec0 busy", 32'(bus.busy), 32'd1);
    tick();
    check("bina exec1", 32'(bus.cpu_inbits), 32'h0);
    check("bina exec1 pc", 32'(bus.pc), 32'd0);
    tick();
    check("bina halted", 32'(bus.halted), 32'd1);
    check("bina pc", 32'(bus.pc), 32'd2);

    // Missing operand: OUTL, PUSH with no operand (stale mem[2] = 1)
    clear_prog();
    load_nib(4'h3); load_nib(4'h1);
    start_prog();
    tick(); tick();
    check("miss fetch0", 32'(bus.cpu_inbits), 32'h3);
    tick();
    check("miss exec0", 32'(bus.cpu_inbits), 32'h0);
    tick();
    check("miss fetch1", 32'(bus.cpu_inbits), 32'h1);
    check("miss pc1", 32'(bus.pc), 32'd1);
    tick();
    check("miss operand", 32'(bus.cpu_inbits), 32'h0);
    tick();
    check("miss halted", 32'(bus.halted), 32'd1);
    check("miss pc", 32'(bus.pc), 32'd3);

    // Step mode: PUSH 7, PUSH 2
    clear_prog();
    load_nib(4'h1); load_nib(4'h7); load_nib(4'h1); load_nib(4'h2);
    bus.step_mode = 1'b1;
    start_prog();
    tick(); tick();
    check("step wait0 inbits", 32'(bus.cpu_inbits), 32'd0);
    check("step wait0 busy", 32'(bus.busy), 32'd0);
    check("step wait0 cpu_rst", 32'(bus.cpu_rst), 32'd0);
    tick(); tick(); tick();
    check("step hold0 pc", 32'(bus.pc), 32'd0);
    check("step hold0 inbits", 32'(bus.cpu_inbits), 32'd0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check("step fetch0", 32'(bus.cpu_inbits), 32'h1);
    check("step fetch0 busy", 32'(bus.busy), 32'd1);
    tick();
    check("step exec0", 32'(bus.cpu_inbits), 32'h7);
    tick();
    check("step wait1 pc", 32'(bus.pc), 32'd2);
    check("step wait1 inbits", 32'(bus.cpu_inbits), 32'd0);
    check("step wait1 busy", 32'(bus.busy), 32'd0);
    tick(); tick();
    check("step hold1 pc", 32'(bus.pc), 32'd2);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check("step fetch1", 32'(bus.cpu_inbits), 32'h1);
    tick();
    check("step exec1", 32'(bus.cpu_inbits), 32'h2);
    tick();
    check("step halted", 32'(bus.halted), 32'd1);
    check("step pc end", 32'(bus.pc), 32'd4);
    bus.step_mode = 1'b0;

    // Empty start, load priority over start, load_ptr saturation
    clear_prog();
    start_prog();
    check("idle empty busy", 32'(bus.busy), 32'd0);
    check("idle empty halted", 32'(bus.halted), 32'd0);
    bus.start = 1'b1;
    load_nib(4'h0);
    bus.start = 1'b0;
    check("load beats start busy", 32'(bus.busy), 32'd0);
    check("load beats start ptr", 32'(dut.load_ptr_q), 32'd1);
    for (int i = 1; i < 16; i++) load_nib(4'(i));
    load_nib(4'hA);
    check("sat load_ptr", 32'(dut.load_ptr_q), 32'd16);
    check("sat mem0", 32'(dut.u_mem.mem[0]), 32'h0);
    check("sat mem15", 32'(dut.u_mem.mem[15]), 32'hF);
    start_prog();
    check("full start cpu_rst", 32'(bus.cpu_rst), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
